// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM state encoding, the NOP used for bubbles and faults, PC increment helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  // addi x0,x0,0; decode uses the same value when it squashes an instruction
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: memory req/ack into a registered Instr; zero-wait memory gives valid one cycle after the request.
// Holds Instr until decode asserts InstrReady; FETCH_ALIGN_CHECK_EN turns misaligned PCs into a FetchFault bubble.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] PC,
  input  logic        Flush,
  output logic        PCEn,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemRData,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic [31:0] InstrPCPlus4,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic        FetchFault
);

  fetch_state_t r_state;
  fetch_state_t w_next;

  logic [31:2] r_fetch_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        w_capture;
  logic        w_fault_set;
  logic        w_misaligned;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // While in REQ the PC input already holds the address being fetched (it only
  // moves on PCEn), so REQ drives it directly; DROP replays the latched copy.
  always_comb begin
    w_next      = r_state;
    w_capture   = 1'b0;
    w_fault_set = 1'b0;
    IMemReq     = 1'b0;
    IMemAddr    = {r_fetch_pc, 2'b00};
    InstrValid  = 1'b0;
    PCEn        = Flush;
    case (r_state)
      IDLE: begin
        w_next = REQ;
      end
      REQ: begin
        if (w_misaligned) begin
          if (!Flush) begin
            w_next      = HOLD;
            w_fault_set = 1'b1;
          end
        end else begin
          IMemReq  = 1'b1;
          IMemAddr = {PC[31:2], 2'b00};
          if (IMemAck && !Flush) begin
            w_capture = 1'b1;
            w_next    = HOLD;
          end else if (!IMemAck && Flush) begin
            w_next = DROP;
          end
        end
      end
      DROP: begin
        IMemReq = 1'b1;
        if (IMemAck) begin
          w_next = REQ;
        end
      end
      HOLD: begin
        InstrValid = 1'b1;
        PCEn       = InstrReady | Flush;
        if (InstrReady || Flush) begin
          w_next = REQ;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_fetch_pc <= '0;
      r_instr    <= NOP_INSTR;
      r_instr_pc <= '0;
    end else begin
      if (r_state == IDLE || r_state == REQ) begin
        r_fetch_pc <= PC[31:2];
      end
      if (w_capture) begin
        r_instr    <= IMemRData;
        r_instr_pc <= PC;
      end else if (w_fault_set) begin
        r_instr    <= NOP_INSTR;
        r_instr_pc <= PC;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_fault;

  assign w_misaligned = (PC[1:0] != 2'b00);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_fault <= 1'b0;
    end else if (w_fault_set) begin
      r_fault <= 1'b1;
    end else if (r_state == HOLD && (InstrReady || Flush)) begin
      r_fault <= 1'b0;
    end
  end

  assign FetchFault = r_fault;
`else
  assign w_misaligned = 1'b0;
  assign FetchFault   = 1'b0;
`endif

  assign Instr        = r_instr;
  assign InstrPC      = r_instr_pc;
  assign InstrPCPlus4 = pc_plus4(r_instr_pc);

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage between `program_counter` and decode. Takes the current PC, runs a req/ack transaction with instruction memory, and holds the returned word in an output register with a valid/ready handshake toward decode. Drives `PCEn` so the PC advances exactly once per instruction consumed. `Flush` handles redirects from taken branches and jumps.

## Interface
- `NOP_INSTR`, default 32'h0000_0013 (`addi x0,x0,0`): value of `Instr` at reset and on faults.
- `CLK`  in  1  clock; all state changes on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `PC`  in  32  current PC from `program_counter`.
- `Flush`  in  1  redirect; the PC is loaded with the target on this edge.
- `PCEn`  out  1  PC update enable into `program_counter`.
- `IMemReq`  out  1  memory request.
- `IMemAddr`  out  32  word-aligned fetch address.
- `IMemAck`  in  1  read data valid; may arrive in the same cycle as `IMemReq`.
- `IMemRData`  in  32  read data.
- `Instr`  out  32  fetched instruction.
- `InstrPC`, `InstrPCPlus4`  out  32 each  address of `Instr`, and that address + 4 (mod 2^32).
- `InstrValid`  out  1  `Instr` is valid.
- `InstrReady`  in  1  decode accepts `Instr`.
- `FetchFault`  out  1  misaligned fetch (see Configuration).

## Operation
- States: `IDLE`, `REQ`, `DROP`, `HOLD`.
- `IDLE`: entered only on reset. Always moves to `REQ` on the next edge and latches `FetchPC <= PC`.
- `REQ`:
  - `IMemReq=1`, `IMemAddr={FetchPC[31:2],2'b00}`.
  - `IMemAck & ~Flush`: capture `Instr<=IMemRData`, `InstrPC<=FetchPC`, go to `HOLD`.
  - `IMemAck & Flush`: discard the data, latch `FetchPC<=PC`, stay in `REQ`.
  - `~IMemAck & Flush`: go to `DROP`.
  - No ack, no flush: stay in `REQ`.
- `DROP`:
  - Keeps `IMemReq=1` and `IMemAddr` unchanged (the memory protocol requires a stable address until ack).
  - `PC` is not latched while in `DROP`.
  - On `IMemAck`: discard the data, latch `FetchPC<=PC`, go to `REQ`.
  - A further `Flush` in `DROP` has no additional effect.
- `HOLD`:
  - `InstrValid=1`; `Instr`/`InstrPC` are stable until the handshake.
  - `InstrReady & ~Flush`: `PCEn=1`, go to `REQ`, latch `FetchPC<=PC+4` (the PC value after this edge).
  - `Flush`: go to `REQ`, latch `FetchPC<=PC_target` (the PC value after this edge); the held instruction is dropped even if `InstrReady=1`.
- `PCEn = (HOLD & InstrReady) | Flush`; combinational.
- `InstrValid` is high only in `HOLD`.
- `InstrPCPlus4 = InstrPC + 32'd4`, 32-bit wrap-around (0xFFFF_FFFC -> 0x0000_0000).
- Reset in any state, including mid-transaction: go to `IDLE` and abandon the request. Memory must tolerate `IMemReq` dropping without ack.

## Timing
- Reset values:
  - state `IDLE`, `IMemReq=0`, `IMemAddr=0`.
  - `Instr=NOP_INSTR`, `InstrPC=0`, `InstrValid=0`, `FetchFault=0`.
  - `PCEn=0`, unless `Flush` is asserted during reset.
- `IMemReq` rises on the first edge after `Reset` falls, which is cycle 1.
- With zero-wait memory (ack in the request cycle): `REQ` -> `HOLD` in 1 cycle. Throughput is 1 instruction per 2 cycles with `InstrReady` held high.
- Each memory wait cycle adds one cycle in `REQ`.
- Flush penalty: no ack pending -> 1 cycle to the new request; ack pending -> the `DROP` wait plus 1 cycle.
- `Flush` and `Reset` together: `Reset` wins.

## Configuration
- Macro: `FETCH_ALIGN_CHECK_EN`.
- Defined: when entering `REQ` (from `IDLE` or `HOLD`) with `FetchPC[1:0]!=0`:
  - No memory request is issued; go directly to `HOLD`.
  - `Instr=NOP_INSTR`, `FetchFault=1`.
  - `FetchFault` clears on the handshake or on `Flush`.
- Not defined: `FetchFault` is tied to 0. `PC[1:0]` is ignored, and the address is always forced to word alignment.

## Structure
- Shared package `fetch_pkg`:
  - `fetch_state_t` enum (`IDLE`, `REQ`, `DROP`, `HOLD`).
  - `NOP_INSTR` constant, shared with the decode flush logic.
- Single module; no sub-module. The output register and the FSM live together.

## Test plan
- Reset held 2 cycles, PC=0: outputs at reset values. Release: `IMemReq=1`, `IMemAddr=0x0` at cycle 1. Ack with 0x00500093: `Instr=0x00500093`, `InstrPC=0`, `InstrPCPlus4=4`, `InstrValid=1` in the next cycle.
- `InstrReady` low 3 cycles in `HOLD`: `Instr` stable, `PCEn=0`. `InstrReady` high: `PCEn=1` for exactly 1 cycle; next request at 0x4.
- 2-wait-cycle memory at PC=0x10: `IMemAddr` stays at 0x10 for 3 cycles; `InstrValid` rises in cycle 4.
- `Flush` in `REQ` with no ack, PC redirected to 0x100: stays on 0x10 until ack. That data is never presented (`InstrValid` stays 0). Next `IMemAddr=0x100`.
- `Flush` during `HOLD` with `InstrReady=1`: held instruction dropped, `PCEn=1`, next request at the target 0x100.
- `FETCH_ALIGN_CHECK_EN` defined, PC=0x102: no `IMemReq`; `InstrValid=1`, `FetchFault=1`, `Instr=0x00000013`. Macro undefined, PC=0x102: `IMemAddr=0x100`, `FetchFault=0`.
